spi_xfer_sequencer: RTL and testbench

SPI_XFER_SEQUENCER -- requirements
Module: spi_xfer_sequencer

---
 rtl/spi_xfer_sequencer.sv | 169 ++++++++++++++++
 tb/tb_spi_xfer_sequencer.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_xfer_sequencer.sv
// Moves TX FIFO words through an SPI shift engine, one at a time. Each word is
// framed by slave select, optionally spaced by idle cycles and grouped into bursts.
module spi_xfer_sequencer #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 8
) (
    input  logic              pclk,
    input  logic              preset_n,
    input  logic              enable,
    input  logic              swr,
    input  logic [CNT_W-1:0]  tx_dly,
    input  logic [CNT_W-1:0]  burst_len,
    input  logic              tx_empty,
    input  logic [DATA_W-1:0] tx_rdata,
    output logic              tx_ren,
    input  logic              rx_full,
    output logic              rx_wen,
    output logic [DATA_W-1:0] rx_wdata,
    output logic              start_req,
    input  logic              start_ack,
    input  logic              xfer_done,
    output logic [DATA_W-1:0] shift_wdata,
    input  logic [DATA_W-1:0] shift_rdata,
    output logic              ss_n,
    output logic              busy,
    output logic              burst_done,
    output logic              rx_ovf_err,
    output logic [2:0]        state_dbg
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_START = 3'd2,
        S_WAIT  = 3'd3,
        S_STORE = 3'd4,
        S_DELAY = 3'd5
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state;
    state_t           next_state;
    logic [CNT_W-1:0] burst_cnt;
    logic [CNT_W-1:0] burst_cnt_inc;
    logic [CNT_W-1:0] dly_cnt;
    logic             burst_last;
    logic             cont_ok;
    logic             capture;

    assign burst_cnt_inc = burst_cnt + CNT_ONE;
    assign burst_last    = (burst_len != '0) && (burst_cnt_inc == burst_len);
    assign cont_ok       = enable && !tx_empty;

    // Handshake: start_req rises on START entry and holds until start_ack is
    // sampled high; the engine may raise xfer_done in that same acknowledge cycle.
    assign capture = xfer_done &&
                     ((state == S_WAIT) || ((state == S_START) && start_ack));

    assign state_dbg = state;

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (cont_ok) next_state = S_LOAD;
            end
            S_LOAD: begin
                next_state = S_START;
            end
            S_START: begin
                if (start_ack) next_state = xfer_done ? S_STORE : S_WAIT;
            end
            S_WAIT: begin
                if (xfer_done) next_state = S_STORE;
            end
            S_STORE: begin
                if (burst_last || !enable) begin
                    next_state = S_IDLE;
                end else if (tx_dly != '0) begin
                    next_state = S_DELAY;
                end else begin
                    next_state = cont_ok ? S_LOAD : S_IDLE;
                end
            end
            S_DELAY: begin
                if (dly_cnt <= CNT_ONE) next_state = cont_ok ? S_LOAD : S_IDLE;
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
        // Soft reset overrides every transition, including in-flight transfers.
        if (swr) next_state = S_IDLE;
    end

    always_comb begin
        tx_ren     = 1'b0;
        rx_wen     = 1'b0;
        rx_ovf_err = 1'b0;
        burst_done = 1'b0;
        start_req  = 1'b0;
        busy       = (state != S_IDLE);
        if (!swr) begin
            case (state)
                S_LOAD: begin
                    tx_ren = !tx_empty;
                end
                S_START: begin
                    start_req = 1'b1;
                end
                S_STORE: begin
                    rx_wen     = !rx_full;
                    rx_ovf_err = rx_full;
                    burst_done = burst_last;
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            ss_n        <= 1'b1;
            shift_wdata <= '0;
            rx_wdata    <= '0;
            burst_cnt   <= '0;
            dly_cnt     <= '0;
        end else if (swr) begin
            ss_n        <= 1'b1;
            shift_wdata <= '0;
            rx_wdata    <= '0;
            burst_cnt   <= '0;
            dly_cnt     <= '0;
        end else begin
            if (state == S_LOAD) shift_wdata <= tx_rdata;
            if (capture) rx_wdata <= shift_rdata;

            // Slave select stays low across LOAD->...->LOAD chains within a frame.
            if (next_state == S_IDLE) begin
                ss_n <= 1'b1;
            end else if (state == S_LOAD) begin
                ss_n <= 1'b0;
            end

            if (next_state == S_IDLE) begin
                burst_cnt <= '0;
            end else if (state == S_STORE) begin
                burst_cnt <= burst_cnt_inc;
            end

            if ((state == S_STORE) && (next_state == S_DELAY)) begin
                dly_cnt <= tx_dly;
            end else if (state == S_DELAY) begin
                dly_cnt <= dly_cnt - CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_spi_xfer_sequencer.sv
// Directed bench for spi_xfer_sequencer: FIFO and shift-engine models around
// the DUT, one task per scenario, scoreboard on received words.
module tb_spi_xfer_sequencer;
    localparam int DATA_W = 32;
    localparam int CNT_W  = 8;
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_STORE = 3'd4;

    logic              pclk = 1'b0;
    logic              preset_n = 1'b0;
    logic              enable = 1'b0;
    logic              swr = 1'b0;
    logic [CNT_W-1:0]  tx_dly = '0;
    logic [CNT_W-1:0]  burst_len = '0;
    logic              tx_empty;
    logic [DATA_W-1:0] tx_rdata;
    logic              tx_ren;
    logic              rx_full;
    logic              rx_wen;
    logic [DATA_W-1:0] rx_wdata;
    logic              start_req;
    logic              start_ack = 1'b0;
    logic              xfer_done = 1'b0;
    logic [DATA_W-1:0] shift_wdata;
    logic [DATA_W-1:0] shift_rdata = '0;
    logic              ss_n;
    logic              busy;
    logic              burst_done;
    logic              rx_ovf_err;
    logic [2:0]        state_dbg;

    int vectors = 0;
    int miscompares = 0;
    logic [DATA_W-1:0] exp_q[$];

    spi_xfer_sequencer #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .pclk(pclk), .preset_n(preset_n), .enable(enable), .swr(swr),
        .tx_dly(tx_dly), .burst_len(burst_len), .tx_empty(tx_empty),
        .tx_rdata(tx_rdata), .tx_ren(tx_ren), .rx_full(rx_full),
        .rx_wen(rx_wen), .rx_wdata(rx_wdata), .start_req(start_req),
        .start_ack(start_ack), .xfer_done(xfer_done), .shift_wdata(shift_wdata),
        .shift_rdata(shift_rdata), .ss_n(ss_n), .busy(busy),
        .burst_done(burst_done), .rx_ovf_err(rx_ovf_err), .state_dbg(state_dbg)
    );

    // clock / reset
    always #5 pclk = ~pclk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // show-ahead TX FIFO model
    logic [DATA_W-1:0] tx_mem [0:31];
    int tx_wr = 0;
    int tx_rd = 0;
    assign tx_empty = (tx_rd == tx_wr);
    assign tx_rdata = tx_mem[tx_rd[4:0]];
    always @(posedge pclk) if (tx_ren && !tx_empty) tx_rd <= tx_rd + 1;

    // RX full is raised for exactly one chosen STORE
    int store_count = 0;
    int full_idx = -1;
    always @(posedge pclk) if (state_dbg == S_STORE) store_count <= store_count + 1;
    assign rx_full = (store_count == full_idx);

    // shift engine model
    logic [DATA_W-1:0] eng_mem [0:31];
    int eng_wr = 0;
    int eng_idx = 0;
    int ack_lat = 1;
    int done_lat = 2;
    logic eng_busy = 1'b0;

    initial begin
        forever begin
            @(posedge pclk); #1;
            if (start_req && preset_n) begin
                eng_busy = 1'b1;
                repeat (ack_lat) begin @(posedge pclk); #1; end
                start_ack = 1'b1;
                if (done_lat == 0) begin
                    xfer_done = 1'b1;
                    shift_rdata = eng_mem[eng_idx[4:0]];
                end
                @(posedge pclk); #1;
                start_ack = 1'b0;
                xfer_done = 1'b0;
                if (done_lat != 0) begin
                    repeat (done_lat - 1) begin @(posedge pclk); #1; end
                    xfer_done = 1'b1;
                    shift_rdata = eng_mem[eng_idx[4:0]];
                    @(posedge pclk); #1;
                    xfer_done = 1'b0;
                end
                eng_idx = eng_idx + 1;
                eng_busy = 1'b0;
            end
        end
    end

    // monitor + scoreboard
    int cyc = 0, tx_ren_cnt = 0, rx_wen_cnt = 0, bd_cnt = 0, ovf_cnt = 0;
    int ss_low_cnt = 0, ss_rise_cnt = 0, wait_cnt = 0, last_store = 0;
    int gap_q[$];
    bit in_frame = 1'b0;
    logic prev_ss = 1'b1;
    logic [DATA_W-1:0] last_wdata = '0;
    logic [DATA_W-1:0] exp_w;

    initial begin
        forever begin
            @(negedge pclk);
            cyc++;
            if (tx_ren) tx_ren_cnt++;
            if (rx_wen) rx_wen_cnt++;
            if (burst_done) bd_cnt++;
            if (rx_ovf_err) ovf_cnt++;
            if (tx_ren || rx_wen) begin
                vectors++;
                if ((tx_ren && tx_empty) || (rx_wen && rx_full)) begin
                    miscompares++;
                    $display("FAIL fifo_guard: tx_ren=%b tx_empty=%b rx_wen=%b rx_full=%b",
                             tx_ren, tx_empty, rx_wen, rx_full);
                end
            end
            if (rx_wen) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL rx_word: got %h, expected no push", rx_wdata);
                end else begin
                    exp_w = exp_q.pop_front();
                    if (rx_wdata !== exp_w) begin
                        miscompares++;
                        $display("FAIL rx_word: got %h, expected %h", rx_wdata, exp_w);
                    end
                end
            end
            if (ss_n === 1'b0) ss_low_cnt++;
            if (prev_ss === 1'b0 && ss_n === 1'b1) ss_rise_cnt++;
            prev_ss = ss_n;
            if (state_dbg == S_WAIT) wait_cnt++;
            if (start_req) last_wdata = shift_wdata;
            if (state_dbg == S_STORE) begin
                last_store = cyc;
                in_frame = 1'b1;
            end else if (state_dbg == S_LOAD && in_frame) begin
                gap_q.push_back(cyc - last_store - 1);
            end else if (state_dbg == S_IDLE) begin
                in_frame = 1'b0;
            end
        end
    end

    // driver tasks
    task automatic push_word(input logic [DATA_W-1:0] tx, input logic [DATA_W-1:0] rx,
                             input bit expect_rx);
        tx_mem[tx_wr[4:0]] = tx;
        tx_wr = tx_wr + 1;
        eng_mem[eng_wr[4:0]] = rx;
        eng_wr = eng_wr + 1;
        if (expect_rx) exp_q.push_back(rx);
    endtask

    task automatic wait_drained(input int budget, output bit timed_out);
        timed_out = 1'b1;
        for (int i = 0; i < budget; i++) begin
            @(negedge pclk);
            if (tx_rd == tx_wr && state_dbg == S_IDLE && !eng_busy) begin
                timed_out = 1'b0;
                break;
            end
        end
        repeat (2) @(negedge pclk);
    endtask

    task automatic test_reset();
        preset_n = 1'b0;
        repeat (2) @(negedge pclk);
        vectors++; if (ss_n !== 1'b1) begin miscompares++; $display("FAIL reset_ss_n: got %b, expected 1", ss_n); end
        vectors++; if (state_dbg !== S_IDLE) begin miscompares++; $display("FAIL reset_state: got %0d, expected 0", state_dbg); end
        vectors++; if (start_req !== 1'b0) begin miscompares++; $display("FAIL reset_start_req: got %b, expected 0", start_req); end
        vectors++; if (tx_ren !== 1'b0 || rx_wen !== 1'b0) begin miscompares++; $display("FAIL reset_strobes: tx_ren=%b rx_wen=%b, expected 0 0", tx_ren, rx_wen); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b, expected 0", busy); end
        vectors++; if (burst_done !== 1'b0 || rx_ovf_err !== 1'b0) begin miscompares++; $display("FAIL reset_pulses: bd=%b ovf=%b, expected 0 0", burst_done, rx_ovf_err); end
        vectors++; if (shift_wdata !== '0) begin miscompares++; $display("FAIL reset_shift_wdata: got %h, expected 0", shift_wdata); end
        vectors++; if (rx_wdata !== '0) begin miscompares++; $display("FAIL reset_rx_wdata: got %h, expected 0", rx_wdata); end
        @(posedge pclk); #1;
        preset_n = 1'b1;
        repeat (2) @(negedge pclk);
        vectors++; if (state_dbg !== S_IDLE || ss_n !== 1'b1) begin miscompares++; $display("FAIL post_reset_idle: state=%0d ss_n=%b, expected 0 1", state_dbg, ss_n); end
    endtask

    task automatic test_single_word();
        int tr, rw, bd, ovf, sl;
        bit to;
        tr = tx_ren_cnt; rw = rx_wen_cnt; bd = bd_cnt; ovf = ovf_cnt; sl = ss_low_cnt;
        tx_dly = 8'd0; burst_len = 8'd1; ack_lat = 2; done_lat = 10;
        push_word(32'hA5A5_0001, 32'h0000_005A, 1'b1);
        enable = 1'b1;
        wait_drained(200, to);
        enable = 1'b0;
        vectors++; if (to) begin miscompares++; $display("FAIL single_timeout: got busy, expected idle within budget"); end
        vectors++; if (tx_ren_cnt - tr != 1) begin miscompares++; $display("FAIL single_tx_ren: got %0d, expected 1", tx_ren_cnt - tr); end
        vectors++; if (rx_wen_cnt - rw != 1) begin miscompares++; $display("FAIL single_rx_wen: got %0d, expected 1", rx_wen_cnt - rw); end
        vectors++; if (bd_cnt - bd != 1) begin miscompares++; $display("FAIL single_burst_done: got %0d, expected 1", bd_cnt - bd); end
        vectors++; if (ovf_cnt - ovf != 0) begin miscompares++; $display("FAIL single_ovf: got %0d, expected 0", ovf_cnt - ovf); end
        vectors++; if (last_wdata !== 32'hA5A5_0001) begin miscompares++; $display("FAIL single_shift_wdata: got %h, expected a5a50001", last_wdata); end
        vectors++; if (ss_low_cnt - sl != 14) begin miscompares++; $display("FAIL single_ss_low_cycles: got %0d, expected 14", ss_low_cnt - sl); end
        vectors++; if (exp_q.size() != 0) begin miscompares++; $display("FAIL single_pending: got %0d, expected 0", exp_q.size()); end
    endtask

    task automatic test_back_to_back();
        int tr, rw, bd, sr;
        bit to;
        tr = tx_ren_cnt; rw = rx_wen_cnt; bd = bd_cnt; sr = ss_rise_cnt;
        gap_q.delete();
        tx_dly = 8'd4; burst_len = 8'd0; ack_lat = 1; done_lat = 3;
        push_word(32'h0000_0011, 32'h0000_0101, 1'b1);
        push_word(32'h0000_0022, 32'h0000_0102, 1'b1);
        push_word(32'h0000_0033, 32'h0000_0103, 1'b1);
        enable = 1'b1;
        wait_drained(300, to);
        enable = 1'b0;
        vectors++; if (to) begin miscompares++; $display("FAIL b2b_timeout: got busy, expected idle within budget"); end
        vectors++; if (tx_ren_cnt - tr != 3) begin miscompares++; $display("FAIL b2b_tx_ren: got %0d, expected 3", tx_ren_cnt - tr); end
        vectors++; if (rx_wen_cnt - rw != 3) begin miscompares++; $display("FAIL b2b_rx_wen: got %0d, expected 3", rx_wen_cnt - rw); end
        vectors++; if (bd_cnt - bd != 0) begin miscompares++; $display("FAIL b2b_burst_done: got %0d, expected 0", bd_cnt - bd); end
        vectors++; if (ss_rise_cnt - sr != 1) begin miscompares++; $display("FAIL b2b_ss_rises: got %0d, expected 1", ss_rise_cnt - sr); end
        vectors++; if (gap_q.size() != 2) begin miscompares++; $display("FAIL b2b_gap_count: got %0d, expected 2", gap_q.size()); end
        for (int i = 0; i < gap_q.size(); i++) begin
            vectors++;
            if (gap_q[i] != 4) begin miscompares++; $display("FAIL b2b_gap%0d: got %0d, expected 4", i, gap_q[i]); end
        end
    endtask

    task automatic test_burst_split();
        int tr, rw, bd, sr;
        bit to;
        tr = tx_ren_cnt; rw = rx_wen_cnt; bd = bd_cnt; sr = ss_rise_cnt;
        tx_dly = 8'd0; burst_len = 8'd2; ack_lat = 0; done_lat = 2;
        for (int i = 1; i <= 5; i++) push_word(32'h0B00_0000 + i, 32'h0C00_0000 + i, 1'b1);
        enable = 1'b1;
        wait_drained(300, to);
        enable = 1'b0;
        vectors++; if (to) begin miscompares++; $display("FAIL burst_timeout: got busy, expected idle within budget"); end
        vectors++; if (tx_ren_cnt - tr != 5) begin miscompares++; $display("FAIL burst_tx_ren: got %0d, expected 5", tx_ren_cnt - tr); end
        vectors++; if (rx_wen_cnt - rw != 5) begin miscompares++; $display("FAIL burst_rx_wen: got %0d, expected 5", rx_wen_cnt - rw); end
        vectors++; if (bd_cnt - bd != 2) begin miscompares++; $display("FAIL burst_done_count: got %0d, expected 2", bd_cnt - bd); end
        vectors++; if (ss_rise_cnt - sr != 3) begin miscompares++; $display("FAIL burst_ss_rises: got %0d, expected 3", ss_rise_cnt - sr); end
    endtask

    task automatic test_overflow();
        int tr, rw, ovf;
        bit to;
        tr = tx_ren_cnt; rw = rx_wen_cnt; ovf = ovf_cnt;
        tx_dly = 8'd0; burst_len = 8'd0; ack_lat = 1; done_lat = 2;
        full_idx = store_count + 1;
        push_word(32'h0D00_0001, 32'h0E00_0001, 1'b1);
        push_word(32'h0D00_0002, 32'h0E00_0002, 1'b0);
        push_word(32'h0D00_0003, 32'h0E00_0003, 1'b1);
        enable = 1'b1;
        wait_drained(300, to);
        enable = 1'b0;
        full_idx = -1;
        vectors++; if (to) begin miscompares++; $display("FAIL ovf_timeout: got busy, expected idle within budget"); end
        vectors++; if (ovf_cnt - ovf != 1) begin miscompares++; $display("FAIL ovf_pulses: got %0d, expected 1", ovf_cnt - ovf); end
        vectors++; if (rx_wen_cnt - rw != 2) begin miscompares++; $display("FAIL ovf_rx_wen: got %0d, expected 2", rx_wen_cnt - rw); end
        vectors++; if (tx_ren_cnt - tr != 3) begin miscompares++; $display("FAIL ovf_tx_ren: got %0d, expected 3", tx_ren_cnt - tr); end
        vectors++; if (exp_q.size() != 0) begin miscompares++; $display("FAIL ovf_pending: got %0d, expected 0", exp_q.size()); end
    endtask

    task automatic test_collision();
        int rw, bd, wc;
        bit to;
        rw = rx_wen_cnt; bd = bd_cnt; wc = wait_cnt;
        tx_dly = 8'd0; burst_len = 8'd1; ack_lat = 1; done_lat = 0;
        push_word(32'h0F00_0001, 32'hC011_15E0, 1'b1);
        enable = 1'b1;
        wait_drained(100, to);
        enable = 1'b0;
        vectors++; if (to) begin miscompares++; $display("FAIL coll_timeout: got busy, expected idle within budget"); end
        vectors++; if (wait_cnt - wc != 0) begin miscompares++; $display("FAIL coll_wait_cycles: got %0d, expected 0", wait_cnt - wc); end
        vectors++; if (rx_wen_cnt - rw != 1) begin miscompares++; $display("FAIL coll_rx_wen: got %0d, expected 1", rx_wen_cnt - rw); end
        vectors++; if (bd_cnt - bd != 1) begin miscompares++; $display("FAIL coll_burst_done: got %0d, expected 1", bd_cnt - bd); end
        vectors++; if (rx_wdata !== 32'hC011_15E0) begin miscompares++; $display("FAIL coll_rx_wdata: got %h, expected c01115e0", rx_wdata); end
    endtask

    task automatic test_abort();
        int rw, ovf, bd;
        bit seen;
        rw = rx_wen_cnt; ovf = ovf_cnt; bd = bd_cnt;
        tx_dly = 8'd0; burst_len = 8'd1; ack_lat = 1; done_lat = 20;
        push_word(32'hDEAD_0001, 32'h0000_0BAD, 1'b0);
        enable = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge pclk);
            if (state_dbg == S_WAIT) begin seen = 1'b1; break; end
        end
        vectors++; if (!seen) begin miscompares++; $display("FAIL abort_reach_wait: got state %0d, expected 3", state_dbg); end
        @(posedge pclk); #1;
        swr = 1'b1;
        @(posedge pclk); #1;
        swr = 1'b0;
        @(negedge pclk);
        vectors++; if (state_dbg !== S_IDLE) begin miscompares++; $display("FAIL abort_state: got %0d, expected 0", state_dbg); end
        vectors++; if (ss_n !== 1'b1) begin miscompares++; $display("FAIL abort_ss_n: got %b, expected 1", ss_n); end
        vectors++; if (start_req !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("FAIL abort_req_busy: start_req=%b busy=%b, expected 0 0", start_req, busy); end
        vectors++; if (shift_wdata !== '0) begin miscompares++; $display("FAIL abort_shift_wdata: got %h, expected 0", shift_wdata); end
        seen = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge pclk);
            if (!eng_busy) begin seen = 1'b1; break; end
        end
        repeat (4) @(negedge pclk);
        enable = 1'b0;
        vectors++; if (!seen) begin miscompares++; $display("FAIL abort_engine_timeout: got busy, expected engine idle"); end
        vectors++; if (state_dbg !== S_IDLE) begin miscompares++; $display("FAIL abort_late_done_state: got %0d, expected 0", state_dbg); end
        vectors++; if (rx_wen_cnt - rw != 0) begin miscompares++; $display("FAIL abort_rx_wen: got %0d, expected 0", rx_wen_cnt - rw); end
        vectors++; if (ovf_cnt - ovf != 0 || bd_cnt - bd != 0) begin miscompares++; $display("FAIL abort_pulses: ovf=%0d bd=%0d, expected 0 0", ovf_cnt - ovf, bd_cnt - bd); end
        vectors++; if (rx_wdata !== '0) begin miscompares++; $display("FAIL abort_rx_wdata: got %h, expected 0", rx_wdata); end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_back_to_back();
        test_burst_split();
        test_overflow();
        test_collision();
        test_abort();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
